text_overlay_renderer: RTL
==========================

Name: text_overlay_renderer

Overview:
- Parametrised successor to the fixed "DDJ" mosaic generator: draws a one-row string of up to N_CHARS 8x16 glyphs at a programmable screen origin.
- Adds a writable character buffer, optional 2x scaling and per-character blink.
- Sits between the VGA sync counters (Qh/Qv) and the colour mux; emits one font bit per pixel with fixed pipeline latency.

Parameters:
- N_CHARS, 8, characters per string (1..64).
- CODE_W, 6, character-code width; font holds 2^CODE_W glyphs.
- FONT_FILE, "font8x16.mem", $readmemb image, 2^CODE_W*16 rows of 8 bits, row address = {code,row[3:0]}.
- ORG_H_DEF, 400, reset horizontal origin in pixels.
- ORG_V_DEF, 256, reset vertical origin in pixels.
- BLINK_LOG2, 5, blink phase toggles every 2^BLINK_LOG2 frame ticks.

Ports:
- reloj  in  1  system/pixel clock; all logic on rising edge.
- resetM  in  1  synchronous reset, active high.
- Qh  in  10  horizontal pixel count.
- Qv  in  10  vertical pixel count.
- video_on  in  1  visible-area flag, aligned with Qh/Qv.
- frame_tick  in  1  one-cycle pulse per frame, during vertical blanking.
- wr_en  in  1  character-buffer write strobe.
- wr_addr  in  6  character slot index.
- wr_code  in  CODE_W  glyph code to store.
- wr_blink  in  1  blink attribute for the slot.
- origin_h  in  10  requested horizontal origin.
- origin_v  in  10  requested vertical origin.
- scale2x  in  1  requested scale: 0 = 8x16 cells, 1 = 16x32 cells.
- clr_busy  out  1  high while the buffer-clear sequence runs.
- pix_on  out  1  font bit for the pixel presented 3 cycles earlier.

Behaviour:
- Reset and control FSM: on resetM the FSM enters CLEAR, slot counter = 0.
  - CLEAR: write {code 0, blink 0} to one slot per cycle; after slot N_CHARS-1 go to RUN. Duration is exactly N_CHARS cycles.
  - RUN: normal operation; returns to CLEAR only on resetM.
  - resetM mid-CLEAR restarts the clear from slot 0.
- Reset values:
  - pix_on = 0; clr_busy = 1 (it stays high through CLEAR, low in RUN); blink counter = 0; blink phase = 1 (visible).
  - Shadow origin = ORG_H_DEF/ORG_V_DEF; shadow scale = 0.
  - Pipeline valid bits cleared.
- Shadow registers: origin_h, origin_v and scale2x are captured only on a cycle with frame_tick=1, so there is no tearing mid-frame.
- Write port, RUN only:
  - wr_en with wr_addr < N_CHARS writes {wr_code, wr_blink}.
  - wr_addr >= N_CHARS is ignored.
  - wr_en during CLEAR is ignored.
  - A write to a slot being read in the same cycle: the read returns the old contents (read-first).
- Geometry, with s = shadow scale:
  - rx = Qh - org_h, ry = Qv - org_v (10-bit).
  - Inside when Qh >= org_h, rx < N_CHARS*8 << s, Qv >= org_v, ry < 16 << s, and video_on = 1.
  - Slot = rx >> (3+s); bit = (rx >> s) & 7, where bit 0 selects font MSB; row = (ry >> s) & 15.
  - Region clipped at Qh/Qv 1023; no wrap-around.
- Pipeline, fixed latency 3:
  - S1 registers inside, slot, bit and row.
  - S2 reads the character buffer.
  - S3 reads the font ROM row; the output mux uses the bit delayed to S3.
  - pix_on = inside_d3 & font_bit & (blink_d3 ? phase : 1).
  - Outside the region, and during CLEAR, pix_on = 0.
- Blink:
  - Each frame_tick increments the BLINK_LOG2-bit counter; on wrap, phase toggles.
  - With phase = 0, slots with blink = 1 output 0.
- Font: code 0 is all zeros.
  - The default FONT_FILE code 1 is 'D' (rows 1..14: F8,6C,66x10,6C,F8).
  - Code 2 is 'J' (rows 1..14: 1E,0Cx9,CCx3,78).
  - Rows 0 and 15 are 00.

Test Plan:
1. Reset, then idle 8 cycles. Required: clr_busy is high for exactly 8 cycles then falls; pix_on = 0 throughout; a scan of the whole frame gives pix_on = 0 everywhere.
2. Write slot0 = 1 ('D'), pulse frame_tick, drive Qv = 257, Qh = 400..407. Required: pix_on, 3 cycles later, reads 1,1,1,1,1,0,0,0.
3. Write slot1 = 2 ('J'), set origin_h = 100 and scale2x = 1, pulse frame_tick, drive Qv = 258 and Qh = 116..131.
   - Qv = 258 gives ry = 2, row 1 (0x1E).
   - Required: pix_on = 0 for six pixels, then 1 for eight, then 0 for two; the old origin of 400 produces no output.
4. Change origin_h mid-frame without frame_tick. Required: output position is unchanged until the next frame_tick.
5. Write slot0 = 1 with blink = 1, then issue 32 frame_ticks. Required: the 'D' row pixels are suppressed from tick 32 until tick 64, then reappear.
6. Write wr_addr = 9 with N_CHARS = 8, and wr_en during CLEAR. Required: no buffer change; Qh = 464 (past the window) gives pix_on = 0.

Source files
------------

// File: rtl/text_overlay_renderer.sv
// text_overlay_renderer
//   Draws a one-row string of up to N_CHARS 8x16 glyphs (or 16x32 when scaled)
//   at a programmable screen origin. Emits one font bit per pixel, three clock
//   cycles after the pixel coordinates are presented.
//
//   The glyph image is a built-in table: code 0 is blank, code 1 is 'D',
//   code 2 is 'J', and every other code is blank.
//
// Ports
//   reloj       pixel clock, all logic on the rising edge
//   resetM      synchronous reset, active high
//   Qh, Qv      horizontal / vertical pixel counters
//   video_on    visible-area flag aligned with Qh/Qv
//   frame_tick  one-cycle pulse per frame (vertical blanking)
//   wr_en       character-buffer write strobe
//   wr_addr     character slot index
//   wr_code     glyph code to store
//   wr_blink    blink attribute for the slot
//   origin_h/v  requested origin, taken on frame_tick
//   scale2x     requested scale, taken on frame_tick
//   clr_busy    high while the buffer is being cleared
//   pix_on      font bit for the pixel presented 3 cycles earlier
module text_overlay_renderer #(
  parameter int N_CHARS    = 8,
  parameter int CODE_W     = 6,
  parameter int ORG_H_DEF  = 400,
  parameter int ORG_V_DEF  = 256,
  parameter int BLINK_LOG2 = 5
) (
  input  logic              reloj,
  input  logic              resetM,
  input  logic [9:0]        Qh,
  input  logic [9:0]        Qv,
  input  logic              video_on,
  input  logic              frame_tick,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              wr_blink,
  input  logic [9:0]        origin_h,
  input  logic [9:0]        origin_v,
  input  logic              scale2x,
  output logic              clr_busy,
  output logic              pix_on
);

  localparam int SLOT_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CHARS - 1);
  localparam logic [10:0] WIN_W0 = 11'(N_CHARS * 8);

  // state    | meaning
  // ST_CLEAR | zeroing one buffer slot per cycle, output forced low
  // ST_RUN   | normal rendering, host writes accepted
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              buf_we;
  logic [SLOT_W-1:0] buf_waddr;
  logic [CODE_W:0]   buf_wdata;
  logic [CODE_W:0]   char_buf_q [N_CHARS];

  logic [9:0]        org_h_q, org_v_q;
  logic              scale_q;
  logic [BLINK_LOG2-1:0] blink_cnt_q;
  logic              phase_q;

  // FSM state register
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_SLOT) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: buffer write port is owned by the clear sequence in ST_CLEAR
  always_comb begin
    clr_busy  = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        clr_busy  = 1'b1;
        buf_we    = 1'b1;
        buf_waddr = clr_cnt_q;
      end
      default: begin
        buf_we    = wr_en && ({1'b0, wr_addr} < 7'(N_CHARS));
        buf_waddr = SLOT_W'(wr_addr);
        buf_wdata = {wr_code, wr_blink};
      end
    endcase
  end

  // Character buffer {code, blink}; no reset, the clear sequence owns init
  always_ff @(posedge reloj) begin
    if (buf_we) char_buf_q[buf_waddr] <= buf_wdata;
  end

  // Shadow geometry and blink phase, updated only on frame_tick
  always_ff @(posedge reloj) begin
    if (resetM) begin
      org_h_q     <= 10'(ORG_H_DEF);
      org_v_q     <= 10'(ORG_V_DEF);
      scale_q     <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (frame_tick) begin
      org_h_q     <= origin_h;
      org_v_q     <= origin_v;
      scale_q     <= scale2x;
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (&blink_cnt_q) phase_q <= ~phase_q;
    end
  end

  // Geometry
  logic [9:0]        rx, ry;
  logic [10:0]       win_w, win_h;
  logic              inside_d;
  logic [SLOT_W-1:0] slot_d;
  logic [2:0]        bit_d;
  logic [3:0]        row_d;

  always_comb begin
    rx       = Qh - org_h_q;
    ry       = Qv - org_v_q;
    win_w    = scale_q ? (WIN_W0 << 1) : WIN_W0;
    win_h    = scale_q ? 11'd32 : 11'd16;
    // Qh >= org_h also keeps rx from wrapping past 1023
    inside_d = (state_q == ST_RUN) && video_on &&
               (Qh >= org_h_q) && (Qv >= org_v_q) &&
               ({1'b0, rx} < win_w) && ({1'b0, ry} < win_h);
    slot_d   = SLOT_W'(scale_q ? (rx >> 4) : (rx >> 3));
    bit_d    = scale_q ? rx[3:1] : rx[2:0];
    row_d    = scale_q ? ry[4:1] : ry[3:0];
  end

  function automatic logic [7:0] glyph_row(input logic [CODE_W-1:0] code,
                                           input logic [3:0] row);
    logic [7:0] r;
    r = 8'h00;
    if (code == CODE_W'(1)) begin
      case (row)
        4'd0, 4'd15: r = 8'h00;
        4'd1, 4'd14: r = 8'hF8;
        4'd2, 4'd13: r = 8'h6C;
        default:     r = 8'h66;
      endcase
    end else if (code == CODE_W'(2)) begin
      case (row)
        4'd0, 4'd15:        r = 8'h00;
        4'd1:               r = 8'h1E;
        4'd11, 4'd12, 4'd13: r = 8'hCC;
        4'd14:              r = 8'h78;
        default:            r = 8'h0C;
      endcase
    end
    return r;
  endfunction

  // Three-stage pixel pipeline
  logic              in1_q, in2_q, in3_q;
  logic [SLOT_W-1:0] slot1_q;
  logic [2:0]        bit1_q, bit2_q, bit3_q;
  logic [3:0]        row1_q, row2_q;
  logic [CODE_W-1:0] code2_q;
  logic              blink2_q, blink3_q;
  logic [7:0]        font3_q;

  always_ff @(posedge reloj) begin
    if (resetM) begin
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      in3_q    <= 1'b0;
      slot1_q  <= '0;
      bit1_q   <= '0;
      bit2_q   <= '0;
      bit3_q   <= '0;
      row1_q   <= '0;
      row2_q   <= '0;
      code2_q  <= '0;
      blink2_q <= 1'b0;
      blink3_q <= 1'b0;
      font3_q  <= '0;
    end else begin
      in1_q    <= inside_d;
      slot1_q  <= slot_d;
      bit1_q   <= bit_d;
      row1_q   <= row_d;
      // read-first: a same-cycle write to slot1_q is seen next read
      in2_q    <= in1_q;
      bit2_q   <= bit1_q;
      row2_q   <= row1_q;
      {code2_q, blink2_q} <= char_buf_q[slot1_q];
      in3_q    <= in2_q;
      bit3_q   <= bit2_q;
      blink3_q <= blink2_q;
      font3_q  <= glyph_row(code2_q, row2_q);
    end
  end

  // bit 0 selects the leftmost (MSB) font column
  assign pix_on = in3_q & font3_q[3'd7 - bit3_q] & (~blink3_q | phase_q) & ~clr_busy;

endmodule
